// File: rtl/seq_div_12_6_if.sv
// Request/result handshake bundle for the 12-bit by 6-bit sequential divider.
// The master side offers dividend/divisor pairs and consumes results.
interface seq_div_12_6_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] quotient;
    logic [5:0]  remainder;
    logic        div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_div_12_6.sv
// Unsigned 12/6 radix-2 restoring divider: one quotient bit per cycle, MSB first.
// A zero divisor skips iteration and returns the all-ones quotient with div_zero set.
module seq_div_12_6 (
    input logic           clk,
    input logic           rst,
    seq_div_12_6_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [3:0] LAST_ITER = 4'd11;

    state_e      state_q, state_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [11:0] shift_q, shift_d;
    logic [5:0]  divisor_q, divisor_d;
    logic [6:0]  prem_q, prem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] quot_q, quot_d;
    logic [5:0]  rem_q, rem_d;
    logic        dz_q, dz_d;

    logic [6:0]  shifted;
    logic [6:0]  trial;
    logic [6:0]  prem_next;
    logic        fits;

    always_comb begin
        shifted   = (prem_q << 1) | {6'd0, shift_q[11]};
        trial     = shifted - {1'b0, divisor_q};
        fits      = (shifted >= {1'b0, divisor_q});
        prem_next = fits ? trial : shifted;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dz_d      = dz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == 6'd0) begin
                        quot_d  = 12'hFFF;
                        rem_d   = 6'd0;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        shift_d   = bus.dividend;
                        divisor_d = bus.divisor;
                        prem_d    = 7'd0;
                        cnt_d     = 4'd0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                prem_d  = prem_next;
                shift_d = {shift_q[10:0], fits};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    quot_d  = {shift_q[10:0], fits};
                    rem_d   = prem_next[5:0];
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every register sample the
        // pre-edge values, independent of statement order in this block.
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= 12'd0;
            divisor_q <= 6'd0;
            prem_q    <= 7'd0;
            cnt_q     <= 4'd0;
            quot_q    <= 12'd0;
            rem_q     <= 6'd0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            prem_q    <= prem_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_seq_div_12_6.sv
// Self-checking bench for seq_div_12_6: directed vector table, reset/throughput
// corner sequences, and a randomized sweep against an arithmetic reference model.
module tb_seq_div_12_6;
    logic clk = 1'b0;
    logic rst;

    seq_div_12_6_if bus ();

    seq_div_12_6 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string ctx    = "";

    typedef struct {
        int dvd;
        int dvs;
        int hold;
        int q;
        int r;
        int dz;
        int lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (%s): got %0d, expected %0d", name, ctx, act, exp);
        end
    endtask

    // Result and cycle-of-first-out_valid (acceptance cycle = 0) straight from the rules.
    function automatic void ref_div(input int a, input int b, output int q, output int r,
                                    output int dz, output int lat);
        if (b == 0) begin
            q = 4095; r = 0; dz = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; dz = 0; lat = 13;
        end
    endfunction

    // Caller is just past a negedge. Offers one pair, waits for the result,
    // holds it for 'hold' cycles under backpressure, then retires it.
    task automatic run_one(input int dvd, input int dvs, input int hold, input int eq,
                           input int er, input int edz, input int elat, input bit garbage);
        int lat;
        ctx = $sformatf("%0d/%0d", dvd, dvs);
        bus.in_valid  = 1'b1;
        bus.dividend  = 12'(dvd);
        bus.divisor   = 6'(dvs);
        bus.out_ready = 1'b0;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            bus.in_valid = garbage;
            if (garbage) begin
                bus.dividend = 12'($urandom);
                bus.divisor  = 6'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(lat), 32'(elat));
        check("quotient", 32'(bus.quotient), 32'(eq));
        check("remainder", 32'(bus.remainder), 32'(er));
        check("div_zero", 32'(bus.div_zero), 32'(edz));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_quotient", 32'(bus.quotient), 32'(eq));
            check("hold_remainder", 32'(bus.remainder), 32'(er));
            check("hold_div_zero", 32'(bus.div_zero), 32'(edz));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("retire_valid", 32'(bus.out_valid), 32'd0);
        check("retire_in_ready", 32'(bus.in_ready), 32'd1);
        check("retained_quotient", 32'(bus.quotient), 32'(eq));
        check("retained_remainder", 32'(bus.remainder), 32'(er));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int q, r, dz, lat, dvd, dvs, hits;
        int seen[$];

        vecs.push_back('{dvd: 100,  dvs: 7,  hold: 0, q: 14,   r: 2,  dz: 0, lat: 13});
        vecs.push_back('{dvd: 1665, dvs: 45, hold: 0, q: 37,   r: 0,  dz: 0, lat: 13});
        vecs.push_back('{dvd: 4095, dvs: 1,  hold: 1, q: 4095, r: 0,  dz: 0, lat: 13});
        vecs.push_back('{dvd: 5,    dvs: 63, hold: 0, q: 0,    r: 5,  dz: 0, lat: 13});
        vecs.push_back('{dvd: 300,  dvs: 0,  hold: 2, q: 4095, r: 0,  dz: 1, lat: 1});
        vecs.push_back('{dvd: 3969, dvs: 63, hold: 5, q: 63,   r: 0,  dz: 0, lat: 13});
        vecs.push_back('{dvd: 0,    dvs: 1,  hold: 0, q: 0,    r: 0,  dz: 0, lat: 13});
        vecs.push_back('{dvd: 4095, dvs: 63, hold: 0, q: 65,   r: 0,  dz: 0, lat: 13});
        vecs.push_back('{dvd: 4094, dvs: 63, hold: 0, q: 64,   r: 62, dz: 0, lat: 13});
        vecs.push_back('{dvd: 62,   dvs: 63, hold: 0, q: 0,    r: 62, dz: 0, lat: 13});

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = 12'd0;
        bus.divisor   = 6'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        ctx = "reset";
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_quotient", 32'(bus.quotient), 32'd0);
        check("reset_remainder", 32'(bus.remainder), 32'd0);
        check("reset_div_zero", 32'(bus.div_zero), 32'd0);
        rst = 1'b0;

        // First vector is offered in the same cycle rst drops.
        foreach (vecs[i])
            run_one(vecs[i].dvd, vecs[i].dvs, vecs[i].hold, vecs[i].q, vecs[i].r,
                    vecs[i].dz, vecs[i].lat, 1'b1);

        // Reset on the 6th CALC cycle aborts 100/7 without a result.
        ctx = "rst_in_calc";
        bus.in_valid = 1'b1;
        bus.dividend = 12'd100;
        bus.divisor  = 6'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        hits = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) hits++;
        end
        check("abort_no_result", 32'(hits), 32'd0);
        run_one(50, 5, 0, 10, 0, 0, 13, 1'b0);

        // Reset while a result is held in DONE discards it.
        ctx = "rst_in_done";
        bus.in_valid = 1'b1;
        bus.dividend = 12'd9;
        bus.divisor  = 6'd3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        hits = 0;
        while (!bus.out_valid && hits < 40) begin
            @(negedge clk);
            hits++;
        end
        check("done_reached", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("done_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("done_rst_quotient", 32'(bus.quotient), 32'd0);
        check("done_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back throughput with in_valid and out_ready held high.
        ctx = "throughput";
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.dividend  = 12'd1000;
        bus.divisor   = 6'd9;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen.push_back(cyc);
                check("tp_quotient", 32'(bus.quotient), 32'd111);
                check("tp_remainder", 32'(bus.remainder), 32'd1);
                if (seen.size() == 3) begin
                    bus.in_valid = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("tp_results", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("tp_period_1", 32'(seen[1] - seen[0]), 32'd14);
            check("tp_period_2", 32'(seen[2] - seen[1]), 32'd14);
        end
        check("tp_idle_after", 32'(bus.in_ready), 32'd1);

        // Randomized pairs with random backpressure against the reference model.
        for (int n = 0; n < 400; n++) begin
            dvd = int'($urandom_range(0, 4095));
            dvs = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 63));
            ref_div(dvd, dvs, q, r, dz, lat);
            run_one(dvd, dvs, int'($urandom_range(0, 3)), q, r, dz, lat, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_div_12_6.md
SEQ_DIV_12_6 -- requirements
Module: seq_div_12_6

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (12-bit dividend matching the 6x6 multiplier product width, 6-bit divisor).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  dividend/divisor pair offered.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 dividend  input  12  unsigned dividend, sampled on acceptance.
REQ-007 divisor  input  6  unsigned divisor, sampled on acceptance.
REQ-008 out_valid  output  1  result present on quotient/remainder/div_zero.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 quotient  output  12  unsigned quotient.
REQ-011 remainder  output  6  unsigned remainder, always < divisor when divisor != 0.
REQ-012 div_zero  output  1  result came from a zero divisor.

Function
REQ-013 The block SHALL compute exact quotient = floor(dividend/divisor) and remainder = dividend mod divisor by radix-2 restoring division, one quotient bit per cycle, MSB first.
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; acceptance = in_valid && in_ready at a rising edge.
REQ-016 On acceptance with divisor != 0: dividend and divisor registered, 7-bit partial remainder cleared, 4-bit iteration counter cleared, state -> CALC.
REQ-017 Each CALC cycle: shift partial remainder left inserting the next dividend bit; if shifted value >= divisor, subtract and set quotient bit to 1, else keep value and set 0.
REQ-018 The partial remainder SHALL be 7 bits wide internally so the shifted value never overflows; the final value fits 6 bits.
REQ-019 After the 12th CALC iteration, state -> DONE; out_valid SHALL first be high exactly 13 cycles after the acceptance edge (12 iteration edges + 1).
REQ-020 On acceptance with divisor == 0: no iterations; state -> DONE on the acceptance edge; quotient = 12'hFFF, remainder = 0, div_zero = 1; out_valid high the cycle after acceptance.
REQ-021 div_zero SHALL be 0 for every nonzero-divisor result.
REQ-022 out_valid SHALL be 1 only in DONE.
REQ-023 While out_valid && !out_ready, quotient, remainder, div_zero SHALL hold stable for any number of cycles.
REQ-024 On out_valid && out_ready at an edge: state -> IDLE; in_ready high the following cycle; no new pair is accepted on the same edge that retires a result.
REQ-025 in_valid, dividend, divisor SHALL be ignored outside IDLE; input changes during CALC SHALL not affect the result in progress.
REQ-026 quotient, remainder, div_zero SHALL retain the last result after retirement until the next result is written.
REQ-027 Back-to-back throughput SHALL be one result per 14 cycles with out_ready and in_valid held high (1 accept + 12 CALC + 1 DONE).

Reset
REQ-028 While rst is high at an edge: state -> IDLE, counter = 0, partial remainder = 0, quotient = 0, remainder = 0, div_zero = 0, out_valid = 0, in_ready = 1 in the following cycle.
REQ-029 rst SHALL take priority over all other inputs, including an in-progress CALC or a held DONE; the aborted operation SHALL produce no result.
REQ-030 After rst deasserts, the first in_valid SHALL be accepted on the first edge at which rst is low.

Verification
REQ-031 dividend=100, divisor=7, out_ready=1 -> out_valid 13 cycles after acceptance, quotient=14, remainder=2, div_zero=0.
REQ-032 Multiplier round-trip: dividend=1665 (37*45), divisor=45 -> quotient=37, remainder=0; dividend=4095, divisor=1 -> quotient=4095, remainder=0; dividend=5, divisor=63 -> quotient=0, remainder=5.
REQ-033 dividend=300, divisor=0 -> out_valid the cycle after acceptance, quotient=12'hFFF, remainder=0, div_zero=1.
REQ-034 dividend=3969, divisor=63, out_ready held 0 for 5 cycles after out_valid -> quotient=63, remainder=0 stable all 5 cycles; in_ready=0 throughout; retire on out_ready=1, in_ready=1 next cycle.
REQ-035 Accept dividend=100, divisor=7; assert rst on the 6th CALC cycle -> next cycle out_valid=0, in_ready=1, quotient=0, remainder=0; new pair 50/5 then yields quotient=10, remainder=0.
REQ-036 Random sweep over all 4096x64 input pairs with random out_ready backpressure -> every result matches exact floor division / modulus (or the div_zero encoding), with no lost or duplicated results.
